// File: rtl/loader_pkg.sv
// Shared types and constants for the SRAM loader: FSM states, default widths and
// scratchpad select codes.
package loader_pkg;

    localparam int unsigned DEFAULT_DATA_WIDTH = 64;
    localparam int unsigned DEFAULT_ADDR_WIDTH = 8;

    localparam logic [1:0] SPAD_WEIGHT = 2'd0;
    localparam logic [1:0] SPAD_INPUT  = 2'd1;

    typedef enum logic [2:0] {
        StIdle,
        StLoadW,
        StLoadX,
        StGap,
        StRoute
    } state_e;

endpackage

// File: rtl/sram_loader_if.sv
// Stream-in / SRAM-write bundle of the loader. The master drives the stream and
// observes the SRAM writes; the slave is the loader itself.
interface sram_loader_if import loader_pkg::*; #(
    parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int unsigned ADDR_WIDTH = DEFAULT_ADDR_WIDTH
);

    logic                  i_s_valid;
    logic [DATA_WIDTH-1:0] i_s_data;
    logic                  o_s_ready;
    logic                  o_write_en;
    logic [ADDR_WIDTH-1:0] o_write_addr;
    logic [1:0]            o_spad_select;
    logic [DATA_WIDTH-1:0] o_data_in;

    modport master (
        output i_s_valid,
        output i_s_data,
        input  o_s_ready,
        input  o_write_en,
        input  o_write_addr,
        input  o_spad_select,
        input  o_data_in
    );

    modport slave (
        input  i_s_valid,
        input  i_s_data,
        output o_s_ready,
        output o_write_en,
        output o_write_addr,
        output o_spad_select,
        output o_data_in
    );

endinterface

// File: rtl/loader_addr_counter.sv
// Beat counter for one load phase: counts accepted beats and returns to zero on the
// terminal beat, so each phase starts at address 0.
module loader_addr_counter #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clear_i,
    input  logic             en_i,
    input  logic [WIDTH-1:0] last_i,
    output logic [WIDTH-1:0] count_o,
    output logic             tc_o
);

    logic [WIDTH-1:0] count_d, count_q;

    assign tc_o    = (count_q == last_i);
    assign count_o = count_q;

    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (en_i) begin
            count_d = tc_o ? '0 : count_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/sram_loader.sv
// Streams a weight block then an input block into SRAM scratchpads, waits a fixed
// gap, then holds the router enable until cleared.
module sram_loader import loader_pkg::*; #(
    parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int unsigned ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
    parameter int unsigned GAP_CYCLES = 2
) (
    input  logic                  i_clk,
    input  logic                  i_nrst,
    input  logic                  i_clear,
    input  logic                  i_start,
    input  logic [ADDR_WIDTH-1:0] i_w_count,
    input  logic [ADDR_WIDTH-1:0] i_x_count,
    sram_loader_if.slave          bus,
    output logic [ADDR_WIDTH-1:0] o_i_addr_end,
    output logic                  o_route_en,
    output logic                  o_busy
);

    state_e                state_q;
    logic [ADDR_WIDTH-1:0] w_cnt_q, x_cnt_q;
    logic [3:0]            gap_q;
    logic                  ready_q;
    logic                  write_en_q;
    logic [ADDR_WIDTH-1:0] write_addr_q;
    logic [1:0]            spad_q;
    logic [DATA_WIDTH-1:0] data_q;

    logic                  beat;
    logic [ADDR_WIDTH-1:0] beat_cnt;
    logic [ADDR_WIDTH-1:0] beat_last;
    logic                  beat_tc;

    // ready_q is high exactly in the load states, so it doubles as the phase qualifier
    assign beat      = bus.i_s_valid & ready_q;
    assign beat_last = (state_q == StLoadX) ? x_cnt_q - 1'b1 : w_cnt_q - 1'b1;

    loader_addr_counter #(
        .WIDTH (ADDR_WIDTH)
    ) u_beat_cnt (
        .clk_i   (i_clk),
        .rst_ni  (i_nrst),
        .clear_i (i_clear),
        .en_i    (beat),
        .last_i  (beat_last),
        .count_o (beat_cnt),
        .tc_o    (beat_tc)
    );

    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            state_q      <= StIdle;
            w_cnt_q      <= '0;
            x_cnt_q      <= '0;
            gap_q        <= '0;
            ready_q      <= 1'b0;
            write_en_q   <= 1'b0;
            write_addr_q <= '0;
            spad_q       <= SPAD_WEIGHT;
            data_q       <= '0;
            o_i_addr_end <= '0;
            o_route_en   <= 1'b0;
            o_busy       <= 1'b0;
        end else begin
            write_en_q <= 1'b0;
            if (i_clear) begin
                state_q    <= StIdle;
                w_cnt_q    <= '0;
                x_cnt_q    <= '0;
                gap_q      <= '0;
                ready_q    <= 1'b0;
                o_route_en <= 1'b0;
                o_busy     <= 1'b0;
            end else begin
                unique case (state_q)
                    StIdle: begin
                        if (i_start && (i_w_count != '0 || i_x_count != '0)) begin
                            w_cnt_q      <= i_w_count;
                            x_cnt_q      <= i_x_count;
                            o_i_addr_end <= '0;
                            ready_q      <= 1'b1;
                            o_busy       <= 1'b1;
                            state_q      <= (i_w_count != '0) ? StLoadW : StLoadX;
                        end
                    end
                    StLoadW: begin
                        if (beat) begin
                            write_en_q   <= 1'b1;
                            write_addr_q <= beat_cnt;
                            spad_q       <= SPAD_WEIGHT;
                            data_q       <= bus.i_s_data;
                            if (beat_tc) begin
                                if (x_cnt_q != '0) begin
                                    state_q <= StLoadX;
                                end else begin
                                    state_q <= StGap;
                                    ready_q <= 1'b0;
                                end
                            end
                        end
                    end
                    StLoadX: begin
                        if (beat) begin
                            write_en_q   <= 1'b1;
                            write_addr_q <= beat_cnt;
                            spad_q       <= SPAD_INPUT;
                            data_q       <= bus.i_s_data;
                            if (beat_tc) begin
                                state_q      <= StGap;
                                ready_q      <= 1'b0;
                                o_i_addr_end <= beat_cnt;
                            end
                        end
                    end
                    StGap: begin
                        if (gap_q == 4'(GAP_CYCLES - 1)) begin
                            gap_q      <= '0;
                            state_q    <= StRoute;
                            o_route_en <= 1'b1;
                        end else begin
                            gap_q <= gap_q + 1'b1;
                        end
                    end
                    StRoute: begin
                    end
                    default: begin
                        state_q <= StIdle;
                    end
                endcase
            end
        end
    end

    assign bus.o_s_ready     = ready_q;
    assign bus.o_write_en    = write_en_q;
    assign bus.o_write_addr  = write_addr_q;
    assign bus.o_spad_select = spad_q;
    assign bus.o_data_in     = data_q;

endmodule

// File: tb/tb_sram_loader.sv
// Randomised and directed bench for sram_loader against a beats-remaining model.
module tb_sram_loader;
    import loader_pkg::*;

    localparam int unsigned DW  = 64;
    localparam int unsigned AW  = 8;
    localparam int unsigned GAP = 2;

    logic          clk   = 1'b0;
    logic          rst_n = 1'b0;
    logic          clear;
    logic          start;
    logic [AW-1:0] w_cnt;
    logic [AW-1:0] x_cnt;
    logic [AW-1:0] aend;
    logic          route;
    logic          busy;

    sram_loader_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    sram_loader #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .GAP_CYCLES (GAP)
    ) dut (
        .i_clk        (clk),
        .i_nrst       (rst_n),
        .i_clear      (clear),
        .i_start      (start),
        .i_w_count    (w_cnt),
        .i_x_count    (x_cnt),
        .bus          (bus),
        .o_i_addr_end (aend),
        .o_route_en   (route),
        .o_busy       (busy)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] rnd64();
        return {$urandom, $urandom};
    endfunction

    function automatic logic [9:0] ent(input logic [1:0] s, input logic [7:0] a);
        return {s, a};
    endfunction

    // Model: beats still owed per phase, gap cycles remaining, and the route level.
    int          m_wc = 0, m_xc = 0, m_wl = 0, m_xl = 0, m_gap = 0, m_aend = 0;
    int          m_addr = 0, m_spad = 0;
    bit          m_route = 0, m_we = 0;
    logic [63:0] m_data = '0;

    task automatic model_step();
        bit loading, mbusy;
        if (!rst_n) begin
            m_wc = 0; m_xc = 0; m_wl = 0; m_xl = 0; m_gap = 0; m_aend = 0;
            m_addr = 0; m_spad = 0; m_route = 0; m_we = 0; m_data = '0;
            return;
        end
        m_we    = 0;
        loading = (m_wl > 0 || m_xl > 0);
        mbusy   = loading || m_gap > 0 || m_route;
        if (clear) begin
            m_wl = 0; m_xl = 0; m_gap = 0; m_route = 0;
        end else if (!mbusy) begin
            if (start && (w_cnt != 0 || x_cnt != 0)) begin
                m_wc = int'(w_cnt); m_xc = int'(x_cnt);
                m_wl = m_wc; m_xl = m_xc; m_aend = 0;
            end
        end else if (loading) begin
            if (bus.i_s_valid) begin
                m_we   = 1;
                m_data = bus.i_s_data;
                if (m_wl > 0) begin
                    m_spad = 0; m_addr = m_wc - m_wl; m_wl--;
                end else begin
                    m_spad = 1; m_addr = m_xc - m_xl; m_xl--;
                    if (m_xl == 0) m_aend = m_xc - 1;
                end
                if (m_wl == 0 && m_xl == 0) m_gap = GAP;
            end
        end else if (m_gap > 0) begin
            m_gap--;
            if (m_gap == 0) m_route = 1;
        end
    endtask

    initial forever begin
        @(posedge clk or negedge rst_n);
        model_step();
    end

    always @(negedge clk) begin
        if (rst_n) begin
            chk("write_en", 64'(bus.o_write_en), 64'(m_we));
            chk("s_ready", 64'(bus.o_s_ready), 64'(m_wl > 0 || m_xl > 0));
            chk("busy", 64'(busy), 64'(m_wl > 0 || m_xl > 0 || m_gap > 0 || m_route));
            chk("route_en", 64'(route), 64'(m_route));
            chk("addr_end", 64'(aend), 64'(m_aend));
            if (m_we) begin
                chk("write_addr", 64'(bus.o_write_addr), 64'(m_addr));
                chk("spad_sel", 64'(bus.o_spad_select), 64'(m_spad));
                chk("data_in", bus.o_data_in, m_data);
            end
        end
    end

    // Write log and timing marks for the directed checks.
    logic [9:0] wlog[$];
    int         cyc = 0, last_we_cyc = 0, route_rise_cyc = 0;
    logic       route_prev = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rst_n && bus.o_write_en) begin
            wlog.push_back({bus.o_spad_select, bus.o_write_addr});
            last_we_cyc = cyc;
        end
        if (route && !route_prev) route_rise_cyc = cyc;
        route_prev = route;
    end

    task automatic idle_clear();
        @(negedge clk);
        clear = 1'b1; start = 1'b0; bus.i_s_valid = 1'b0;
        @(negedge clk);
        clear = 1'b0;
        #1 wlog.delete();
    endtask

    task automatic launch(input int w, input int x, input logic v);
        @(negedge clk);
        start = 1'b1; w_cnt = 8'(w); x_cnt = 8'(x);
        bus.i_s_valid = v; bus.i_s_data = rnd64();
        @(negedge clk);
        start = 1'b0; bus.i_s_data = rnd64();
    endtask

    task automatic run_until_route(input int budget, input string name);
        int n = 0;
        while (!route && n < budget) begin
            @(negedge clk);
            bus.i_s_data = rnd64();
            n++;
        end
        #1;
        chk({name, "_route_reached"}, 64'(route), 64'd1);
    endtask

    task automatic chk_log(input string name, input logic [9:0] exp[$]);
        chk({name, "_len"}, 64'(wlog.size()), 64'(exp.size()));
        for (int i = 0; i < exp.size() && i < wlog.size(); i++) begin
            chk($sformatf("%s_w%0d", name, i), 64'(wlog[i]), 64'(exp[i]));
        end
    endtask

    initial begin
        logic [9:0] e[$];
        int         nz;
        clear = 1'b0; start = 1'b0; w_cnt = '0; x_cnt = '0;
        bus.i_s_valid = 1'b0; bus.i_s_data = '0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_ready", 64'(bus.o_s_ready), 64'd0);
        chk("rst_we", 64'(bus.o_write_en), 64'd0);
        chk("rst_addr", 64'(bus.o_write_addr), 64'd0);
        chk("rst_spad", 64'(bus.o_spad_select), 64'd0);
        chk("rst_data", bus.o_data_in, 64'd0);
        chk("rst_aend", 64'(aend), 64'd0);
        chk("rst_route", 64'(route), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // w=3, x=4, valid held high
        idle_clear();
        launch(3, 4, 1'b1);
        run_until_route(40, "r040");
        e.delete();
        for (int i = 0; i < 3; i++) e.push_back(ent(2'd0, 8'(i)));
        for (int i = 0; i < 4; i++) e.push_back(ent(2'd1, 8'(i)));
        chk_log("r040", e);
        chk("r040_gap", 64'(route_rise_cyc - last_we_cyc), 64'd2);
        chk("r040_aend", 64'(aend), 64'd3);

        // w=0, x=2, then an ignored start with both counts zero
        idle_clear();
        launch(0, 2, 1'b1);
        run_until_route(20, "r041");
        e.delete();
        e.push_back(ent(2'd1, 8'd0));
        e.push_back(ent(2'd1, 8'd1));
        chk_log("r041", e);
        idle_clear();
        launch(0, 0, 1'b1);
        #1;
        chk("r041_zero_busy", 64'(busy), 64'd0);
        chk("r041_zero_ready", 64'(bus.o_s_ready), 64'd0);
        chk("r041_aend_hold", 64'(aend), 64'd1);

        // w=4 with valid toggling
        idle_clear();
        launch(4, 0, 1'b0);
        for (int i = 0; i < 8; i++) begin
            bus.i_s_valid = (i % 2 == 0);
            bus.i_s_data  = rnd64();
            @(negedge clk);
        end
        bus.i_s_valid = 1'b0;
        run_until_route(20, "r042");
        e.delete();
        for (int i = 0; i < 4; i++) e.push_back(ent(2'd0, 8'(i)));
        chk_log("r042", e);

        // clear coinciding with the second weight beat
        idle_clear();
        launch(3, 1, 1'b0);
        bus.i_s_valid = 1'b1;
        @(negedge clk);
        clear = 1'b1; bus.i_s_data = rnd64();
        @(negedge clk);
        clear = 1'b0; bus.i_s_valid = 1'b0;
        #1;
        chk("r043_we", 64'(bus.o_write_en), 64'd0);
        chk("r043_ready", 64'(bus.o_s_ready), 64'd0);
        chk("r043_busy", 64'(busy), 64'd0);
        chk("r043_len", 64'(wlog.size()), 64'd1);

        // reset during LOAD_X, then a fresh w=1, x=1 load
        idle_clear();
        launch(2, 3, 1'b1);
        repeat (3) begin
            @(negedge clk);
            bus.i_s_data = rnd64();
        end
        #2 rst_n = 1'b0;
        #1;
        chk("r044_rst_busy", 64'(busy), 64'd0);
        chk("r044_rst_ready", 64'(bus.o_s_ready), 64'd0);
        chk("r044_rst_aend", 64'(aend), 64'd0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        wlog.delete();
        launch(1, 1, 1'b1);
        run_until_route(20, "r044");
        e.delete();
        e.push_back(ent(2'd0, 8'd0));
        e.push_back(ent(2'd1, 8'd0));
        chk_log("r044", e);
        chk("r044_aend", 64'(aend), 64'd0);

        // w=255 full-range weight load
        idle_clear();
        launch(255, 0, 1'b1);
        run_until_route(300, "r045");
        chk("r045_len", 64'(wlog.size()), 64'd255);
        if (wlog.size() > 0) chk("r045_last", 64'(wlog[wlog.size()-1]), 64'(ent(2'd0, 8'd254)));
        nz = 0;
        foreach (wlog[i]) if (wlog[i][9:8] != 2'd0) nz++;
        chk("r045_spad", 64'(nz), 64'd0);

        // randomised traffic, including starts while busy and random clears
        idle_clear();
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            start         = ($urandom_range(0, 7) == 0);
            w_cnt         = ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom_range(1, 6));
            x_cnt         = ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom_range(1, 6));
            bus.i_s_valid = ($urandom_range(0, 3) != 0);
            bus.i_s_data  = rnd64();
            clear         = ($urandom_range(0, 49) == 0);
        end
        @(negedge clk);
        clear = 1'b0; start = 1'b0; bus.i_s_valid = 1'b0;
        @(negedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/sram_loader.md
SRAM_LOADER -- requirements
Module: sram_loader

Interface
REQ-001 Parameter DATA_WIDTH, default 64, SRAM word width.
REQ-002 Parameter ADDR_WIDTH, default 8, SRAM address and count width.
REQ-003 Parameter GAP_CYCLES, default 2, idle cycles between the last write and route enable (range 1..15).
REQ-004 The block SHALL have one clock; reset is asynchronous and active-low.
REQ-005 Port i_clk, input, 1, clock; all state changes on the rising edge.
REQ-006 Port i_nrst, input, 1, reset (asynchronous, active-low).
REQ-007 Port i_clear, input, 1, synchronous abort/clear back to IDLE.
REQ-008 Port i_start, input, 1, single-cycle start request; sampled only in IDLE.
REQ-009 Port i_w_count, input, ADDR_WIDTH, number of weight words; captured on start.
REQ-010 Port i_x_count, input, ADDR_WIDTH, number of input words; captured on start.
REQ-011 Port i_s_valid, input, 1, stream word valid.
REQ-012 Port i_s_data, input, DATA_WIDTH, stream word.
REQ-013 Port o_s_ready, output, 1, stream ready.
REQ-014 Port o_write_en, output, 1, SRAM write strobe.
REQ-015 Port o_write_addr, output, ADDR_WIDTH, SRAM write address.
REQ-016 Port o_spad_select, output, 2, target scratchpad: 0 = weight, 1 = input.
REQ-017 Port o_data_in, output, DATA_WIDTH, SRAM write data.
REQ-018 Port o_i_addr_end, output, ADDR_WIDTH, last input address written.
REQ-019 Port o_route_en, output, 1, router enable level.
REQ-020 Port o_busy, output, 1, high in any state other than IDLE.

Function
REQ-021 The FSM SHALL have states IDLE, LOAD_W, LOAD_X, GAP and ROUTE.
REQ-022 From IDLE, i_start SHALL go to LOAD_W if w_count != 0, else to LOAD_X if x_count != 0; with both counts zero the start is ignored.
REQ-023 o_s_ready SHALL be 1 exactly in LOAD_W and LOAD_X; a beat transfers when i_s_valid and o_s_ready are both 1.
REQ-024 Each transferred beat SHALL appear on the write outputs the next cycle (1-cycle latency), as a one-cycle o_write_en with o_data_in equal to the beat.
REQ-025 The write address SHALL start at 0 in each load phase and increment by 1 per beat.
REQ-026 o_spad_select SHALL be 0 for LOAD_W beats and 1 for LOAD_X beats.
REQ-027 The beat numbered w_count-1 SHALL move the FSM LOAD_W->LOAD_X, or LOAD_W->GAP when x_count == 0.
REQ-028 The beat numbered x_count-1 SHALL move the FSM LOAD_X->GAP.
REQ-029 o_s_ready SHALL drop on the cycle after the last beat, so no extra beat is accepted.
REQ-030 GAP SHALL last exactly GAP_CYCLES cycles, then enter ROUTE.
REQ-031 o_route_en SHALL be high for the whole of ROUTE and only there; ROUTE holds until i_clear.
REQ-032 o_i_addr_end SHALL equal x_count-1 once LOAD_X completes, and hold its value until the next accepted start (0 if x_count == 0).
REQ-033 i_clear SHALL win over i_start and over a simultaneous beat; the next state is IDLE, counters are zeroed, and the beat is dropped.
REQ-034 i_start outside IDLE SHALL be ignored.
REQ-035 i_s_valid low mid-phase SHALL stall the load with no write and no address change.

Reset
REQ-036 Asynchronous assertion of i_nrst SHALL force IDLE, all counters to 0, and every output to 0, including o_i_addr_end.
REQ-037 Reset mid-load SHALL abandon the transfer; after release, the next start begins again at address 0.

Structure
REQ-038 Package loader_pkg SHALL hold the state enum, DATA_WIDTH/ADDR_WIDTH defaults, and SPAD_WEIGHT = 2'd0, SPAD_INPUT = 2'd1.
REQ-039 One sub-module, loader_addr_counter (clear, enable, terminal-count flag), SHALL be instantiated for the beat counter; the rest is flat.

Verification
REQ-040 Start with w=3, x=4, valid held high -> writes to weight addresses 0,1,2, then input addresses 0..3; route_en rises 2 cycles after the last write; o_i_addr_end = 3.
REQ-041 w=0, x=2 -> only spad 1 writes at addresses 0,1; w=0, x=0 with start -> stays IDLE with o_busy = 0.
REQ-042 w=4 with valid toggling 1,0,1,0 -> writes only on accepted beats, addresses contiguous 0..3, no gaps in addressing.
REQ-043 i_clear on the same cycle as the 2nd weight beat -> no write for that beat, IDLE next cycle, o_s_ready = 0.
REQ-044 i_nrst low during LOAD_X, then restart with w=1, x=1 -> writes weight address 0 then input address 0; o_i_addr_end = 0.
REQ-045 w=255 -> last weight write at address 254, no counter wrap, and exactly 255 beats accepted.
